sub_bytes_seq: RTL



---
 rtl/sub_bytes_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: LANES S-boxes time-multiplexed over a WORD_BYTES-byte word.
// Define SUB_BYTES_INV_EN to add the per-word `inv` input that selects the inverse S-box.
module sub_bytes_seq #(
   parameter int WORD_BYTES = 4,
   parameter int LANES      = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*WORD_BYTES-1:0] in_data,
`ifdef SUB_BYTES_INV_EN
   input  logic                    inv,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*WORD_BYTES-1:0] out_data,
   output logic                    busy
);

   localparam int STEPS = (LANES > 0) ? WORD_BYTES / LANES : 1;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   if (WORD_BYTES < 1 || LANES < 1) begin : g_bad_size
      $error("sub_bytes_seq: WORD_BYTES and LANES must both be at least 1");
   end else if (WORD_BYTES % LANES != 0) begin : g_bad_lanes
      $error("sub_bytes_seq: LANES must divide WORD_BYTES");
   end

   // Tables packed MSB-first: entry x lives at bits [2047-8*x -: 8].
   localparam logic [2047:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      return SBOX_FWD[2047 - 8*int'(b) -: 8];
   endfunction

`ifdef SUB_BYTES_INV_EN
   localparam logic [2047:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [7:0] sbox_inv(input logic [7:0] b);
      return SBOX_INV[2047 - 8*int'(b) -: 8];
   endfunction

   logic inv_q;
`endif

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state, state_next;
   logic [CW-1:0]           step_cnt;
   logic [8*WORD_BYTES-1:0] work_q, work_next, out_q;
   logic [7:0]              lane_in  [LANES];
   logic [7:0]              lane_out [LANES];
   logic                    accept;

   assign accept   = in_valid && in_ready;
   assign out_data = out_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // In DONE the handshake is combinational from out_ready so a new word can follow with no gap.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (step_cnt == LAST) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_next = in_valid ? BUSY : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Each BUSY cycle substitutes the LANES bytes selected by step_cnt and writes them back in place.
   always_comb begin
      work_next = work_q;
      lane_in   = '{default: 8'h00};
      lane_out  = '{default: 8'h00};
      for (int l = 0; l < LANES; l++) begin
         lane_in[l] = work_q[8*WORD_BYTES-1-8*(int'(step_cnt)*LANES+l) -: 8];
`ifdef SUB_BYTES_INV_EN
         lane_out[l] = inv_q ? sbox_inv(lane_in[l]) : sbox_fwd(lane_in[l]);
`else
         lane_out[l] = sbox_fwd(lane_in[l]);
`endif
         work_next[8*WORD_BYTES-1-8*(int'(step_cnt)*LANES+l) -: 8] = lane_out[l];
      end
   end

   // out_q is separate from the working register so the presented result never changes mid-word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_cnt <= '0;
         work_q   <= '0;
         out_q    <= '0;
`ifdef SUB_BYTES_INV_EN
         inv_q    <= 1'b0;
`endif
      end else if (accept) begin
         step_cnt <= '0;
         work_q   <= in_data;
`ifdef SUB_BYTES_INV_EN
         inv_q    <= inv;
`endif
      end else if (state == BUSY) begin
         work_q <= work_next;
         if (step_cnt == LAST) begin
            step_cnt <= '0;
            out_q    <= work_next;
         end else begin
            step_cnt <= step_cnt + CW'(1);
         end
      end
   end

endmodule
